// File: rtl/ucsbece154a_mc_controller.sv
// ucsbece154a_mc_controller: multicycle RV32 control FSM with memory wait states, trap state and retire counter
module ucsbece154a_mc_controller #(
    parameter int STALL_EN = 1,
    parameter int BNE_EN   = 1,
    parameter int JALR_EN  = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             RegWrite_o,
    output logic             AdrSrc_o,
    output logic [1:0]       ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ResultSrc_o,
    output logic [2:0]       ALUControl_o,
    output logic [2:0]       ImmSrc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE_R = 4'd6,
        ALU_WB    = 4'd7,
        EXECUTE_I = 4'd8,
        JAL       = 4'd9,
        BEQ       = 4'd10,
        LUI       = 4'd11,
        JALR      = 4'd12,
        TRAP      = 4'd13
    } state_t;

    state_t     state, state_next;
    logic [1:0] alu_op, alu_op_n, src_a_n, src_b_n, result_n;
    logic       adr_n, reg_write_n, mem_write_n;
    logic       ir_write_q, ir_write_n, pc_update_q, pc_update_n, branch_q, branch_n;
    logic       ready, taken, retire;

    assign ready  = (STALL_EN == 0) || mem_ready_i;
    assign taken  = funct3_i[0] ? ~zero_i : zero_i;
    assign retire = (state == MEM_WB || state == MEM_WRITE || state == ALU_WB || state == BEQ)
                    && state_next == FETCH;

    assign PCWrite_o = (branch_q & taken) | (pc_update_q & ready);
    assign IRWrite_o = ir_write_q & ready;

    // Next state: opcode dispatch in Decode, memory-facing states wait for ready
    always_comb begin
        state_next = state;
        case (state)
            FETCH:     state_next = ready ? DECODE : FETCH;
            DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_next = MEM_ADR;
                    OP_R:         state_next = EXECUTE_R;
                    OP_I:         state_next = EXECUTE_I;
                    OP_B:         state_next = (funct3_i == 3'b001 && BNE_EN == 0) ? TRAP : BEQ;
                    OP_JAL:       state_next = JAL;
                    OP_LUI:       state_next = LUI;
                    OP_JALR:      state_next = (JALR_EN != 0) ? JALR : TRAP;
                    default:      state_next = TRAP;
                endcase
            end
            MEM_ADR:   state_next = op_i[5] ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_next = ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_next = ready ? FETCH : MEM_WRITE;
            EXECUTE_R, EXECUTE_I, JAL, LUI, JALR: state_next = ALU_WB;
            MEM_WB, ALU_WB, BEQ: state_next = FETCH;
            default:   state_next = TRAP;
        endcase
    end

    // Control values of the state being entered; don't-care fields are driven 0
    always_comb begin
        src_a_n     = 2'b00;
        src_b_n     = 2'b00;
        adr_n       = 1'b0;
        result_n    = 2'b00;
        alu_op_n    = 2'b00;
        ir_write_n  = 1'b0;
        pc_update_n = 1'b0;
        reg_write_n = 1'b0;
        mem_write_n = 1'b0;
        branch_n    = 1'b0;
        case (state_next)
            FETCH: begin
                src_b_n     = 2'b10;
                result_n    = 2'b10;
                ir_write_n  = 1'b1;
                pc_update_n = 1'b1;
            end
            DECODE: begin
                src_a_n = 2'b01;
                src_b_n = 2'b01;
            end
            MEM_ADR: begin
                src_a_n = 2'b10;
                src_b_n = 2'b01;
            end
            MEM_READ:  adr_n = 1'b1;
            MEM_WB: begin
                result_n    = 2'b01;
                reg_write_n = 1'b1;
            end
            MEM_WRITE: begin
                adr_n       = 1'b1;
                mem_write_n = 1'b1;
            end
            EXECUTE_R: begin
                src_a_n  = 2'b10;
                alu_op_n = 2'b10;
            end
            EXECUTE_I: begin
                src_a_n  = 2'b10;
                src_b_n  = 2'b01;
                alu_op_n = 2'b10;
            end
            ALU_WB: begin
                reg_write_n = 1'b1;
                // after jalr the link value OldPC+4 is recomputed here
                src_a_n     = (state == JALR) ? 2'b01 : 2'b00;
                src_b_n     = (state == JALR) ? 2'b10 : 2'b00;
            end
            JAL: begin
                src_a_n     = 2'b01;
                src_b_n     = 2'b10;
                pc_update_n = 1'b1;
            end
            JALR: begin
                src_a_n     = 2'b10;
                src_b_n     = 2'b01;
                result_n    = 2'b10;
                pc_update_n = 1'b1;
            end
            BEQ: begin
                src_a_n  = 2'b10;
                alu_op_n = 2'b01;
                branch_n = 1'b1;
            end
            LUI: begin
                src_b_n  = 2'b01;
                alu_op_n = 2'b11;
            end
            default: ;
        endcase
    end

    // State, registered controls, sticky trap flag and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            ALUSrcA_o   <= 2'b00;
            ALUSrcB_o   <= 2'b10;
            AdrSrc_o    <= 1'b0;
            ResultSrc_o <= 2'b10;
            alu_op      <= 2'b00;
            ir_write_q  <= 1'b1;
            pc_update_q <= 1'b1;
            RegWrite_o  <= 1'b0;
            MemWrite_o  <= 1'b0;
            branch_q    <= 1'b0;
            illegal_o   <= 1'b0;
            retired_o   <= '0;
        end else begin
            state       <= state_next;
            ALUSrcA_o   <= src_a_n;
            ALUSrcB_o   <= src_b_n;
            AdrSrc_o    <= adr_n;
            ResultSrc_o <= result_n;
            alu_op      <= alu_op_n;
            ir_write_q  <= ir_write_n;
            pc_update_q <= pc_update_n;
            RegWrite_o  <= reg_write_n;
            MemWrite_o  <= mem_write_n;
            branch_q    <= branch_n;
            illegal_o   <= illegal_o | (state_next == TRAP);
            if (retire) retired_o <= retired_o + CNT_W'(1);
        end
    end

    // Immediate format straight from the opcode so it is valid in Decode
    always_comb begin
        case (op_i)
            OP_LW, OP_I, OP_JALR: ImmSrc_o = 3'b000;
            OP_SW:                ImmSrc_o = 3'b001;
            OP_B:                 ImmSrc_o = 3'b010;
            OP_JAL:               ImmSrc_o = 3'b011;
            OP_LUI:               ImmSrc_o = 3'b100;
            default:              ImmSrc_o = 3'b000;
        endcase
    end

    // ALU decoder: ALUOp 10 defers to funct3/funct7
    always_comb begin
        case (alu_op)
            2'b00: ALUControl_o = ALU_ADD;
            2'b01: ALUControl_o = ALU_SUB;
            2'b11: ALUControl_o = ALU_PASS;
            default: begin
                case (funct3_i)
                    3'b000:  ALUControl_o = (funct7_i & op_i[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl_o = ALU_SLT;
                    3'b110:  ALUControl_o = ALU_OR;
                    3'b111:  ALUControl_o = ALU_AND;
                    default: ALUControl_o = ALU_ADD;
                endcase
            end
        endcase
    end
endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// tb_ucsbece154a_mc_controller: random instruction streams against a phase-table model of the controller
module tb_ucsbece154a_mc_controller;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_JAL = 6, K_LUI = 7, K_JALR = 8, K_BAD = 9;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AW, P_JAL, P_JALR, P_BEQ, P_LUI, P_TRAP} phase_t;

    typedef struct packed {
        logic [1:0] a, b, res, op;
        logic       adr, ka, kb, kres, kop, kadr, irw, pcu, rw, mw, br;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = OP_LW;
    logic [2:0] funct3 = 3'b000;
    logic       funct7 = 1'b0, zero = 1'b0, mem_ready = 1'b0;

    logic       pcw [2], mw [2], irw [2], rw [2], adr [2], ill [2];
    logic [1:0] asrc [2], bsrc [2], res [2];
    logic [2:0] aluc [2], imm [2];
    logic [31:0] ret0;
    logic [3:0]  ret1;

    int          sel = 0;
    bit          stall_en = 1'b1, bne_en = 1'b1, jalr_en = 1'b1;
    logic [31:0] cnt_mask = 32'hFFFF_FFFF;
    int unsigned ret_m = 0;
    logic        ill_m = 1'b0;
    int          total = 0, passed = 0;

    ucsbece154a_mc_controller dut (
        .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .PCWrite_o(pcw[0]), .MemWrite_o(mw[0]), .IRWrite_o(irw[0]), .RegWrite_o(rw[0]),
        .AdrSrc_o(adr[0]), .ALUSrcA_o(asrc[0]), .ALUSrcB_o(bsrc[0]), .ResultSrc_o(res[0]),
        .ALUControl_o(aluc[0]), .ImmSrc_o(imm[0]), .illegal_o(ill[0]), .retired_o(ret0)
    );

    ucsbece154a_mc_controller #(.STALL_EN(0), .BNE_EN(0), .JALR_EN(0), .CNT_W(4)) dut_alt (
        .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .PCWrite_o(pcw[1]), .MemWrite_o(mw[1]), .IRWrite_o(irw[1]), .RegWrite_o(rw[1]),
        .AdrSrc_o(adr[1]), .ALUSrcA_o(asrc[1]), .ALUSrcB_o(bsrc[1]), .ResultSrc_o(res[1]),
        .ALUControl_o(aluc[1]), .ImmSrc_o(imm[1]), .illegal_o(ill[1]), .retired_o(ret1)
    );

    always #5 clk = ~clk;

    // Watchdog so a broken design can never stall the run
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, total=%0d", total);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One row of the control table written as "ALUSrcA,ALUSrcB,AdrSrc,ResultSrc,ALUOp"; x marks don't-care
    function automatic ctrl_t row(input string s, input logic [4:0] en);
        ctrl_t c;
        c      = '0;
        c.ka   = s[0] != "x";
        c.a    = {s[0] == "1", s[1] == "1"};
        c.kb   = s[3] != "x";
        c.b    = {s[3] == "1", s[4] == "1"};
        c.kadr = s[6] != "x";
        c.adr  = s[6] == "1";
        c.kres = s[8] != "x";
        c.res  = {s[8] == "1", s[9] == "1"};
        c.kop  = s[11] != "x";
        c.op   = {s[11] == "1", s[12] == "1"};
        {c.irw, c.pcu, c.rw, c.mw, c.br} = en;
        return c;
    endfunction

    // en = {IRWrite, PCUpdate, RegWrite, MemWrite, Branch}
    function automatic ctrl_t spec_ctrl(input phase_t p, input bit after_jalr);
        case (p)
            P_F:     return row("00,10,0,10,00", 5'b11000);
            P_D:     return row("01,01,x,xx,00", 5'b00000);
            P_MA:    return row("10,01,x,xx,00", 5'b00000);
            P_MR:    return row("xx,xx,1,00,xx", 5'b00000);
            P_MWB:   return row("xx,xx,x,01,xx", 5'b00100);
            P_MW:    return row("xx,xx,1,00,xx", 5'b00010);
            P_ER:    return row("10,00,x,xx,10", 5'b00000);
            P_EI:    return row("10,01,x,xx,10", 5'b00000);
            P_AW:    return after_jalr ? row("01,10,x,00,00", 5'b00100) : row("xx,xx,x,00,xx", 5'b00100);
            P_JAL:   return row("01,10,x,00,00", 5'b01000);
            P_JALR:  return row("10,01,x,10,00", 5'b01000);
            P_BEQ:   return row("10,00,x,00,01", 5'b00001);
            P_LUI:   return row("xx,01,x,xx,11", 5'b00000);
            default: return row("xx,xx,x,xx,xx", 5'b00000);
        endcase
    endfunction

    // {known, ALUControl} for a given ALUOp
    function automatic logic [3:0] exp_alu(input logic known, input logic [1:0] o);
        if (!known) return 4'b0000;
        case (o)
            2'b00: return {1'b1, A_ADD};
            2'b01: return {1'b1, A_SUB};
            2'b11: return {1'b1, 3'b111};
            default: begin
                case (funct3)
                    3'b000:  return {1'b1, (funct7 && op[5]) ? A_SUB : A_ADD};
                    3'b010:  return {1'b1, A_SLT};
                    3'b110:  return {1'b1, A_OR};
                    3'b111:  return {1'b1, A_AND};
                    default: return 4'b0000;
                endcase
            end
        endcase
    endfunction

    // {known, ImmSrc} for an opcode
    function automatic logic [3:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_LW, OP_I, OP_JALR: return 4'b1000;
            OP_SW:                return 4'b1001;
            OP_B:                 return 4'b1010;
            OP_JAL:               return 4'b1011;
            OP_LUI:               return 4'b1100;
            default:              return 4'b0000;
        endcase
    endfunction

    task automatic observe(input phase_t p, input bit after_jalr);
        ctrl_t      c;
        logic       rdy, taken;
        logic [3:0] e;
        c     = spec_ctrl(p, after_jalr);
        rdy   = !stall_en || mem_ready;
        taken = funct3[0] ? ~zero : zero;
        if (c.ka) check("alusrca", 32'(asrc[sel]), 32'(c.a));
        if (c.kb) check("alusrcb", 32'(bsrc[sel]), 32'(c.b));
        if (c.kadr) check("adrsrc", 32'(adr[sel]), 32'(c.adr));
        if (c.kres) check("resultsrc", 32'(res[sel]), 32'(c.res));
        check("regwrite", 32'(rw[sel]), 32'(c.rw));
        check("memwrite", 32'(mw[sel]), 32'(c.mw));
        check("irwrite", 32'(irw[sel]), 32'(c.irw & rdy));
        check("pcwrite", 32'(pcw[sel]), 32'((c.br & taken) | (c.pcu & rdy)));
        e = exp_alu(c.kop, c.op);
        if (e[3]) check("alucontrol", 32'(aluc[sel]), 32'(e[2:0]));
        e = exp_imm(op);
        if (e[3]) check("immsrc", 32'(imm[sel]), 32'(e[2:0]));
        check("illegal", 32'(ill[sel]), 32'(ill_m));
        check("retired", sel != 0 ? 32'(ret1) : ret0, ret_m & cnt_mask);
    endtask

    // Pulse reset with no clock edge in between and check the asynchronous Fetch state
    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1;
        ill_m = 1'b0;
        ret_m = 0;
        observe(P_F, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Drive one instruction through its expected phase sequence; abort >= 0 resets in that phase
    task automatic run(input int kind, input logic [2:0] f3, input logic f7, input int abort);
        phase_t     q[$];
        logic [6:0] opc;
        int         waits;
        bit         adv;
        q.push_back(P_F);
        q.push_back(P_D);
        case (kind)
            K_LW: begin opc = OP_LW; q.push_back(P_MA); q.push_back(P_MR); q.push_back(P_MWB); end
            K_SW: begin opc = OP_SW; q.push_back(P_MA); q.push_back(P_MW); end
            K_R:  begin opc = OP_R; q.push_back(P_ER); q.push_back(P_AW); end
            K_I:  begin opc = OP_I; q.push_back(P_EI); q.push_back(P_AW); end
            K_BEQ, K_BNE: begin
                opc = OP_B;
                q.push_back((f3 == 3'b001 && !bne_en) ? P_TRAP : P_BEQ);
            end
            K_JAL: begin opc = OP_JAL; q.push_back(P_JAL); q.push_back(P_AW); end
            K_LUI: begin opc = OP_LUI; q.push_back(P_LUI); q.push_back(P_AW); end
            K_JALR: begin
                opc = OP_JALR;
                if (jalr_en) begin q.push_back(P_JALR); q.push_back(P_AW); end
                else q.push_back(P_TRAP);
            end
            default: begin opc = OP_BAD; q.push_back(P_TRAP); end
        endcase
        for (int i = 0; i < q.size(); i++) begin
            waits = 0;
            do begin
                @(negedge clk);
                if (i == 0 && waits == 0) begin
                    op     = opc;
                    funct3 = f3;
                    funct7 = f7;
                end
                mem_ready = (waits >= 6) || ($urandom_range(0, 3) != 0);
                zero      = 1'($urandom_range(0, 1));
                #1;
                if (q[i] == P_TRAP) ill_m = 1'b1;
                observe(q[i], i > 0 && q[i-1] == P_JALR);
                if (i == abort) begin
                    pulse_reset();
                    return;
                end
                waits++;
                adv = (q[i] == P_TRAP) ? (waits >= 20)
                    : !(stall_en && !mem_ready && (q[i] == P_F || q[i] == P_MR || q[i] == P_MW));
                @(posedge clk);
            end while (!adv);
        end
        if (q[q.size()-1] == P_TRAP) pulse_reset();
        else ret_m++;
    endtask

    task automatic run_rand(input int kind);
        logic [2:0] f3;
        case (kind)
            K_LW, K_SW: f3 = 3'b010;
            K_BEQ:      f3 = 3'b000;
            K_BNE:      f3 = 3'b001;
            K_R, K_I: begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b010;
                    2:       f3 = 3'b110;
                    3:       f3 = 3'b111;
                    default: f3 = 3'b001;
                endcase
            end
            default: f3 = 3'($urandom_range(0, 7));
        endcase
        run(kind, f3, 1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 observe(P_F, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        run(K_LW, 3'b010, 1'b0, -1);
        for (int n = 0; n < 150; n++) run_rand($urandom_range(0, 8));
        run(K_R, 3'b000, 1'b1, 2);
        run(K_R, 3'b000, 1'b1, -1);
        run(K_BAD, 3'b000, 1'b0, -1);
        run(K_BNE, 3'b001, 1'b0, -1);

        sel      = 1;
        stall_en = 1'b0;
        bne_en   = 1'b0;
        jalr_en  = 1'b0;
        cnt_mask = 32'h0000_000F;
        pulse_reset();
        repeat (17) run(K_R, 3'b000, 1'b0, -1);
        #1 check("retired_wrap", 32'(ret1), 32'd1);
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            run_rand(k == K_BNE ? K_BEQ : (k == K_JALR ? K_I : k));
        end
        run(K_BNE, 3'b001, 1'b0, -1);
        run(K_JALR, 3'b000, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
